prog_ctr: RTL

PROG_CTR -- requirements
Module: prog_ctr

---
 rtl/prog_ctr.sv | 108 ++++++++++
 1 files changed

// File: rtl/prog_ctr.sv
// prog_ctr: program counter for an instruction fetch stage.
// IDLE / RUN / HALTED sequencing with stall, absolute jump, relative branch and halt.
// Optional macro PROG_CTR_LINK_EN adds call/return using a single link register.
module prog_ctr #(
    parameter int unsigned D     = 12,
    parameter int unsigned OFF_W = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [D-1:0]     i_start_addr,
    input  logic             i_stall,
    input  logic             i_jump_en,
    input  logic [D-1:0]     i_jump_addr,
    input  logic             i_branch_en,
    input  logic [OFF_W-1:0] i_branch_off,
    input  logic             i_halt,
`ifdef PROG_CTR_LINK_EN
    input  logic             i_call_en,
    input  logic             i_ret_en,
`endif
    output logic [D-1:0]     o_prog_ctr_out,
    output logic             o_fetch_valid,
    output logic             o_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t         r_state;
    logic [D-1:0]   r_pc;
    logic           r_fetch_valid;
    logic           r_done;

    logic [D-1:0]   w_pc_inc;
    logic [D-1:0]   w_off_ext;
    logic [D-1:0]   w_branch_tgt;

`ifdef PROG_CTR_LINK_EN
    logic [D-1:0]   r_link;
`endif

    // Sequential and branch targets; D-bit adds wrap naturally in both directions.
    assign w_pc_inc     = r_pc + D'(1);
    assign w_off_ext    = D'($signed(i_branch_off));
    assign w_branch_tgt = r_pc + w_off_ext;

    // State, PC and registered status flags; reset overrides everything.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_IDLE;
            r_pc          <= '0;
            r_fetch_valid <= 1'b0;
            r_done        <= 1'b0;
`ifdef PROG_CTR_LINK_EN
            r_link        <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED: begin
                    if (i_start) begin
                        r_pc          <= i_start_addr;
                        r_state       <= ST_RUN;
                        r_fetch_valid <= 1'b1;
                        r_done        <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (i_halt) begin
                        r_state       <= ST_HALTED;
                        r_fetch_valid <= 1'b0;
                        r_done        <= 1'b1;
                    end else if (i_stall) begin
                        r_pc          <= r_pc;
                    end
`ifdef PROG_CTR_LINK_EN
                    else if (i_ret_en) begin
                        r_pc          <= r_link;
                    end else if (i_call_en) begin
                        r_link        <= w_pc_inc;
                        r_pc          <= i_jump_addr;
                    end
`endif
                    else if (i_jump_en) begin
                        r_pc          <= i_jump_addr;
                    end else if (i_branch_en) begin
                        r_pc          <= w_branch_tgt;
                    end else begin
                        r_pc          <= w_pc_inc;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_fetch_valid <= 1'b0;
                    r_done        <= 1'b0;
                end
            endcase
        end
    end

    assign o_prog_ctr_out = r_pc;
    assign o_fetch_valid  = r_fetch_valid;
    assign o_done         = r_done;

endmodule
